pasta_modop_scheduler: RTL and testbench

PASTA_MODOP_SCHEDULER -- requirements
Module: pasta_modop_scheduler

---
 rtl/pasta_modop_scheduler_pkg.sv | 25 ++
 rtl/pasta_modop_scheduler_if.sv | 41 ++++
 rtl/pasta_rr_channel.sv | 98 +++++++++
 rtl/pasta_modop_scheduler.sv | 65 ++++++
 tb/tb_pasta_modop_scheduler.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pasta_modop_scheduler_pkg.sv
// Shared constants and types for the PASTA modular-operation scheduler.
// Coefficient format, modulus, requester indices and default latencies.
package pasta_modop_scheduler_pkg;

   localparam int unsigned BITLEN  = 17;
   localparam int unsigned PASTA_S = 32;
   localparam int unsigned VEC_W   = BITLEN * PASTA_S;
   localparam int unsigned Q       = 65537;

   localparam int unsigned NUM_REQ            = 3;
   localparam int unsigned REQ_MAT_MUL        = 0;
   localparam int unsigned REQ_ROUND_CONSTANT = 1;
   localparam int unsigned REQ_MIX_COLUMN_SB  = 2;

   localparam int unsigned DEF_MUL_LAT = 4;
   localparam int unsigned DEF_ADD_LAT = 2;

   typedef logic [VEC_W-1:0] pasta_vec_t;

   // Width of a round-robin pointer over n requesters (at least one bit).
   function automatic int unsigned ptr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pasta_modop_scheduler_if.sv
// Requester, wrapper and response signals of the modop scheduler.
// slave = scheduler side, master = requester/wrapper side.
interface pasta_modop_scheduler_if #(
   parameter int unsigned NREQ = pasta_modop_scheduler_pkg::NUM_REQ,
   parameter int unsigned W    = pasta_modop_scheduler_pkg::VEC_W
);

   logic [NREQ-1:0]   mul_req;
   logic [NREQ*W-1:0] mul_a;
   logic [NREQ*W-1:0] mul_b;
   logic [NREQ-1:0]   mul_gnt;
   logic [NREQ-1:0]   add_req;
   logic [NREQ*W-1:0] add_a;
   logic [NREQ*W-1:0] add_b;
   logic [NREQ-1:0]   add_gnt;
   logic [NREQ-1:0]   lock;
   logic [W-1:0]      mm_in1;
   logic [W-1:0]      mm_in2;
   logic [W-1:0]      mm_out;
   logic [W-1:0]      ma_in1;
   logic [W-1:0]      ma_in2;
   logic [W-1:0]      ma_out;
   logic [NREQ-1:0]   mul_rsp_valid;
   logic [W-1:0]      mul_rsp_data;
   logic [NREQ-1:0]   add_rsp_valid;
   logic [W-1:0]      add_rsp_data;
   logic              busy;

   modport slave (
      input  mul_req, mul_a, mul_b, add_req, add_a, add_b, lock, mm_out, ma_out,
      output mul_gnt, add_gnt, mm_in1, mm_in2, ma_in1, ma_in2,
             mul_rsp_valid, mul_rsp_data, add_rsp_valid, add_rsp_data, busy
   );

   modport master (
      output mul_req, mul_a, mul_b, add_req, add_a, add_b, lock, mm_out, ma_out,
      input  mul_gnt, add_gnt, mm_in1, mm_in2, ma_in1, ma_in2,
             mul_rsp_valid, mul_rsp_data, add_rsp_valid, add_rsp_data, busy
   );

endinterface

// File: rtl/pasta_rr_channel.sv
// One scheduler channel: round-robin arbiter with lock, registered operand
// outputs to a shared arithmetic wrapper, and a requester tag pipeline.
module pasta_rr_channel
   import pasta_modop_scheduler_pkg::*;
#(
   parameter int unsigned NREQ = NUM_REQ,
   parameter int unsigned W    = VEC_W,
   parameter int unsigned LAT  = DEF_MUL_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   lock,
   input  logic [NREQ*W-1:0] a,
   input  logic [NREQ*W-1:0] b,
   output logic [NREQ-1:0]   gnt_c,
   output logic [W-1:0]      in1_q,
   output logic [W-1:0]      in2_q,
   output logic [NREQ-1:0]   rsp_valid_q,
   output logic              busy_c
);

   localparam int unsigned PW     = ptr_w(NREQ);
   localparam int unsigned STAGES = LAT - 1;

   logic [PW-1:0]                ptr_q, ptr_d;
   logic [STAGES-1:0][NREQ-1:0]  tag_q, tag_d;
   logic [W-1:0]                 in1_d, in2_d;
   logic [NREQ-1:0]              rsp_valid_d;
   logic [PW-1:0]                idx_c;
   logic [PW-1:0]                sel_c;
   logic                         accept_c;

   // First requester at or after the pointer wins; nothing granted in reset or flush.
   always_comb begin
      gnt_c    = '0;
      sel_c    = '0;
      idx_c    = '0;
      accept_c = 1'b0;
      if (rst && !flush) begin
         for (int unsigned k = 0; k < NREQ; k++) begin
            idx_c = PW'((32'(ptr_q) + k) % NREQ);
            if (!accept_c && req[idx_c]) begin
               accept_c     = 1'b1;
               sel_c        = idx_c;
               gnt_c[idx_c] = 1'b1;
            end
         end
      end
   end

   // Operand capture, pointer update and tag shift; flush empties the channel.
   always_comb begin
      ptr_d       = ptr_q;
      in1_d       = '0;
      in2_d       = '0;
      tag_d       = '0;
      rsp_valid_d = '0;
      if (!flush) begin
         tag_d[0] = gnt_c;
         for (int s = 1; s < int'(STAGES); s++) begin
            tag_d[s] = tag_q[s-1];
         end
         rsp_valid_d = tag_q[STAGES-1];
         if (accept_c) begin
            in1_d = a[32'(sel_c)*W +: W];
            in2_d = b[32'(sel_c)*W +: W];
            if (lock[sel_c]) begin
               ptr_d = sel_c;
            end else if (32'(sel_c) == NREQ - 1) begin
               ptr_d = '0;
            end else begin
               ptr_d = sel_c + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q       <= '0;
         tag_q       <= '0;
         in1_q       <= '0;
         in2_q       <= '0;
         rsp_valid_q <= '0;
      end else begin
         ptr_q       <= ptr_d;
         tag_q       <= tag_d;
         in1_q       <= in1_d;
         in2_q       <= in2_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign busy_c = |tag_q;

endmodule

// File: rtl/pasta_modop_scheduler.sv
// Shares one mod_mul_wrapper and one mod_add_wrapper among the PASTA
// requesters through two independent round-robin channels.
module pasta_modop_scheduler #(
   parameter int unsigned BITLEN  = pasta_modop_scheduler_pkg::BITLEN,
   parameter int unsigned LANES   = pasta_modop_scheduler_pkg::PASTA_S,
   parameter int unsigned NREQ    = pasta_modop_scheduler_pkg::NUM_REQ,
   parameter int unsigned MUL_LAT = pasta_modop_scheduler_pkg::DEF_MUL_LAT,
   parameter int unsigned ADD_LAT = pasta_modop_scheduler_pkg::DEF_ADD_LAT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   pasta_modop_scheduler_if.slave   bus
);
   import pasta_modop_scheduler_pkg::*;

   localparam int unsigned W = BITLEN * LANES;

   logic mul_busy_c;
   logic add_busy_c;

   pasta_rr_channel #(
      .NREQ (NREQ),
      .W    (W),
      .LAT  (MUL_LAT)
   ) u_mul_ch (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .req         (bus.mul_req),
      .lock        (bus.lock),
      .a           (bus.mul_a),
      .b           (bus.mul_b),
      .gnt_c       (bus.mul_gnt),
      .in1_q       (bus.mm_in1),
      .in2_q       (bus.mm_in2),
      .rsp_valid_q (bus.mul_rsp_valid),
      .busy_c      (mul_busy_c)
   );

   pasta_rr_channel #(
      .NREQ (NREQ),
      .W    (W),
      .LAT  (ADD_LAT)
   ) u_add_ch (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .req         (bus.add_req),
      .lock        (bus.lock),
      .a           (bus.add_a),
      .b           (bus.add_b),
      .gnt_c       (bus.add_gnt),
      .in1_q       (bus.ma_in1),
      .in2_q       (bus.ma_in2),
      .rsp_valid_q (bus.add_rsp_valid),
      .busy_c      (add_busy_c)
   );

   // Wrapper results reach the requesters untouched.
   assign bus.mul_rsp_data = bus.mm_out;
   assign bus.add_rsp_data = bus.ma_out;
   assign bus.busy         = mul_busy_c | add_busy_c;

endmodule

// File: tb/tb_pasta_modop_scheduler.sv
// Scoreboard bench for pasta_modop_scheduler with behavioural mod-q wrappers.
module tb_pasta_modop_scheduler;
   import pasta_modop_scheduler_pkg::*;

   localparam int unsigned W  = VEC_W;
   localparam int unsigned NR = NUM_REQ;

   typedef struct {
      logic [NR-1:0]     gnt;
      logic [BITLEN-1:0] val;
      int                due;
   } exp_t;

   logic clk;
   logic rst;
   logic flush;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   exp_t mul_q[$];
   exp_t add_q[$];

   // Hand-computed per-requester results (lane value, mod 65537).
   logic [BITLEN-1:0] mul_exp[NR];
   logic [BITLEN-1:0] add_exp[NR];

   pasta_vec_t mm_pipe[DEF_MUL_LAT-1];
   pasta_vec_t ma_pipe[DEF_ADD_LAT-1];

   pasta_modop_scheduler_if bus();

   pasta_modop_scheduler dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic pasta_vec_t rep(input logic [BITLEN-1:0] v);
      pasta_vec_t r;
      for (int l = 0; l < PASTA_S; l++) r[l*BITLEN +: BITLEN] = v;
      return r;
   endfunction

   function automatic pasta_vec_t mulv(input pasta_vec_t x, input pasta_vec_t y);
      pasta_vec_t r;
      longint p;
      for (int l = 0; l < PASTA_S; l++) begin
         p = longint'(x[l*BITLEN +: BITLEN]) * longint'(y[l*BITLEN +: BITLEN]);
         r[l*BITLEN +: BITLEN] = BITLEN'(p % longint'(Q));
      end
      return r;
   endfunction

   function automatic pasta_vec_t addv(input pasta_vec_t x, input pasta_vec_t y);
      pasta_vec_t r;
      longint s;
      for (int l = 0; l < PASTA_S; l++) begin
         s = longint'(x[l*BITLEN +: BITLEN]) + longint'(y[l*BITLEN +: BITLEN]);
         r[l*BITLEN +: BITLEN] = BITLEN'(s % longint'(Q));
      end
      return r;
   endfunction

   function automatic logic [NR-1:0] oh(input int unsigned i);
      return NR'(1) << i;
   endfunction

   // Behavioural wrappers: LAT-1 register stages after the scheduler's operand flops.
   always @(posedge clk) begin
      mm_pipe[0] <= mulv(bus.mm_in1, bus.mm_in2);
      for (int i = 1; i < DEF_MUL_LAT - 1; i++) mm_pipe[i] <= mm_pipe[i-1];
      ma_pipe[0] <= addv(bus.ma_in1, bus.ma_in2);
      for (int i = 1; i < DEF_ADD_LAT - 1; i++) ma_pipe[i] <= ma_pipe[i-1];
   end
   assign bus.mm_out = mm_pipe[DEF_MUL_LAT-2];
   assign bus.ma_out = ma_pipe[DEF_ADD_LAT-2];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
   endtask

   task automatic push_mul(input int unsigned r);
      exp_t e;
      e.gnt = oh(r);
      e.val = mul_exp[r];
      e.due = cyc + DEF_MUL_LAT;
      mul_q.push_back(e);
   endtask

   task automatic push_add(input int unsigned r);
      exp_t e;
      e.gnt = oh(r);
      e.val = add_exp[r];
      e.due = cyc + DEF_ADD_LAT;
      add_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every response strobe is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (bus.mul_rsp_valid != '0) begin
            if (mul_q.size() == 0) begin
               check("mul_rsp_unexpected", 64'(bus.mul_rsp_valid), 64'(0));
            end else begin
               e = mul_q.pop_front();
               check("mul_rsp_valid", 64'(bus.mul_rsp_valid), 64'(e.gnt));
               check("mul_rsp_cycle", 64'(cyc), 64'(e.due));
               check("mul_rsp_data", 64'(bus.mul_rsp_data[BITLEN-1:0]), 64'(e.val));
               check("mul_rsp_lanes", 64'(bus.mul_rsp_data == rep(e.val)), 64'(1));
            end
         end
         if (bus.add_rsp_valid != '0) begin
            if (add_q.size() == 0) begin
               check("add_rsp_unexpected", 64'(bus.add_rsp_valid), 64'(0));
            end else begin
               e = add_q.pop_front();
               check("add_rsp_valid", 64'(bus.add_rsp_valid), 64'(e.gnt));
               check("add_rsp_cycle", 64'(cyc), 64'(e.due));
               check("add_rsp_data", 64'(bus.add_rsp_data[BITLEN-1:0]), 64'(e.val));
               check("add_rsp_lanes", 64'(bus.add_rsp_data == rep(e.val)), 64'(1));
            end
         end
      end
   end

   initial begin
      logic [BITLEN-1:0] ma[NR];
      logic [BITLEN-1:0] mb[NR];
      logic [BITLEN-1:0] aa[NR];
      logic [BITLEN-1:0] ab[NR];
      ma = '{17'd3, 17'd2, 17'd65536};
      mb = '{17'd3, 17'd5, 17'd65536};
      aa = '{17'd1, 17'd10, 17'd65536};
      ab = '{17'd2, 17'd20, 17'd2};
      mul_exp = '{17'd9, 17'd10, 17'd1};
      add_exp = '{17'd3, 17'd30, 17'd1};

      rst         = 1'b0;
      flush       = 1'b0;
      bus.lock    = '0;
      bus.mul_req = '1;
      bus.add_req = '1;
      for (int i = 0; i < int'(NR); i++) begin
         bus.mul_a[i*W +: W] = rep(ma[i]);
         bus.mul_b[i*W +: W] = rep(mb[i]);
         bus.add_a[i*W +: W] = rep(aa[i]);
         bus.add_b[i*W +: W] = rep(ab[i]);
      end

      // Reset state: grants blocked and all registered outputs clear.
      #2;
      check("rst_mul_gnt", 64'(bus.mul_gnt), 64'(0));
      check("rst_add_gnt", 64'(bus.add_gnt), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_mm_in1", 64'(bus.mm_in1 != '0), 64'(0));
      check("rst_ma_in2", 64'(bus.ma_in2 != '0), 64'(0));
      check("rst_mul_rsp_valid", 64'(bus.mul_rsp_valid), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      bus.mul_req = '0;
      bus.add_req = '0;
      rst = 1'b1;
      tick();

      // Contention on mul from pointer 0: 0,1,2,0,1,2.
      bus.mul_req = 3'b111;
      for (int k = 0; k < 6; k++) begin
         #2;
         check("mul_gnt_rr", 64'(bus.mul_gnt), 64'(oh(k % 3)));
         push_mul(k % 3);
         tick();
      end
      bus.mul_req = '0;
      #2;
      check("busy_burst", 64'(bus.busy), 64'(1));
      repeat (6) tick();

      // Single mat_mul op: 3*3 = 9 in every lane.
      bus.mul_req = oh(REQ_MAT_MUL);
      #2;
      check("mul_gnt_single", 64'(bus.mul_gnt), 64'(oh(REQ_MAT_MUL)));
      push_mul(REQ_MAT_MUL);
      tick();
      bus.mul_req = '0;
      #2;
      check("mm_in1_lane0", 64'(bus.mm_in1[BITLEN-1:0]), 64'(3));
      check("mm_in2_lane31", 64'(bus.mm_in2[W-1 -: BITLEN]), 64'(3));
      tick();
      check("mm_in1_idle_zero", 64'(bus.mm_in1 != '0), 64'(0));
      repeat (5) tick();

      // Lock on the add channel holds round_constant's grant.
      bus.add_req = oh(REQ_MAT_MUL) | oh(REQ_ROUND_CONSTANT);
      for (int k = 0; k < 9; k++) begin
         bus.lock = (k >= 1 && k <= 6) ? oh(REQ_ROUND_CONSTANT) : '0;
         #2;
         if (k == 0 || k == 8) begin
            check("add_gnt_lock", 64'(bus.add_gnt), 64'(oh(REQ_MAT_MUL)));
            push_add(REQ_MAT_MUL);
         end else begin
            check("add_gnt_lock", 64'(bus.add_gnt), 64'(oh(REQ_ROUND_CONSTANT)));
            push_add(REQ_ROUND_CONSTANT);
         end
         tick();
      end
      bus.add_req = '0;
      bus.lock    = '0;
      repeat (4) tick();

      // Simultaneous mul and add by mix_column_sb; add wraps 65536+2 -> 1.
      bus.mul_req = oh(REQ_MIX_COLUMN_SB);
      bus.add_req = oh(REQ_MIX_COLUMN_SB);
      #2;
      check("mul_gnt_dual", 64'(bus.mul_gnt), 64'(oh(REQ_MIX_COLUMN_SB)));
      check("add_gnt_dual", 64'(bus.add_gnt), 64'(oh(REQ_MIX_COLUMN_SB)));
      push_mul(REQ_MIX_COLUMN_SB);
      push_add(REQ_MIX_COLUMN_SB);
      tick();
      bus.mul_req = '0;
      bus.add_req = '0;
      repeat (6) tick();

      // Flush drops three in-flight muls and suppresses grants in its cycle.
      bus.mul_req = 3'b111;
      for (int k = 0; k < 3; k++) begin
         #2;
         check("mul_gnt_preflush", 64'(bus.mul_gnt), 64'(oh(k)));
         tick();
      end
      bus.add_req = oh(REQ_MAT_MUL);
      flush = 1'b1;
      #2;
      check("flush_mul_gnt", 64'(bus.mul_gnt), 64'(0));
      check("flush_add_gnt", 64'(bus.add_gnt), 64'(0));
      check("busy_preflush", 64'(bus.busy), 64'(1));
      tick();
      flush = 1'b0;
      bus.mul_req = '0;
      bus.add_req = 3'b111;
      #2;
      check("busy_postflush", 64'(bus.busy), 64'(0));
      check("mm_in1_postflush", 64'(bus.mm_in1 != '0), 64'(0));
      check("add_gnt_ptr_hold", 64'(bus.add_gnt), 64'(oh(REQ_MAT_MUL)));
      push_add(REQ_MAT_MUL);
      tick();
      bus.add_req = '0;
      repeat (8) tick();

      // Async reset mid-burst: outputs clear at once, pointer restarts at 0.
      bus.mul_req = oh(0) | oh(1);
      for (int k = 0; k < 2; k++) begin
         #2;
         check("mul_gnt_prerst", 64'(bus.mul_gnt), 64'(oh(k)));
         tick();
      end
      #2;
      rst = 1'b0;
      #1;
      check("arst_mul_gnt", 64'(bus.mul_gnt), 64'(0));
      check("arst_busy", 64'(bus.busy), 64'(0));
      check("arst_mm_in1", 64'(bus.mm_in1 != '0), 64'(0));
      check("arst_mul_rsp_valid", 64'(bus.mul_rsp_valid), 64'(0));
      tick();
      rst = 1'b1;
      bus.mul_req = '0;
      repeat (6) tick();
      bus.mul_req = 3'b111;
      #2;
      check("mul_gnt_ptr_restart", 64'(bus.mul_gnt), 64'(oh(0)));
      push_mul(0);
      tick();
      bus.mul_req = '0;
      repeat (10) tick();

      check("mul_q_drained", 64'(mul_q.size()), 64'(0));
      check("add_q_drained", 64'(add_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
